// File: rtl/idma_frontend_arbiter.sv
// Round-robin arbiter that shares one iDMA midend/backend between NumPorts frontends.
// Latency: the request path is combinational (zero cycles); completions are routed back in the same cycle.
// Backpressure: a stalled grant stays locked until its handshake; new requests stop while the owner-ID FIFO is full.
//
// Optional feature: define IDMA_FRONTEND_ARBITER_PERF_EN to add per-port grant counters
// (perf_grants_o) and their synchronous clear input (perf_clear_i).
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   burst_req_i/valid_i/ready_o per-frontend request channel
//   meta_o                      per-frontend metadata (backend_idle broadcast, trans_complete routed)
//   burst_req_o/valid_o/ready_i arbitrated request channel to the midend
//   meta_i                      metadata from the midend
//   busy_o                      frontend has at least one outstanding transfer

package idma_frontend_arbiter_pkg;
  typedef struct packed {
    logic backend_idle;
    logic trans_complete;
  } meta_default_t;
endpackage

module idma_frontend_arbiter #(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         burst_req_t    = logic,
  parameter type         meta_t         = idma_frontend_arbiter_pkg::meta_default_t
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
`ifdef IDMA_FRONTEND_ARBITER_PERF_EN
  input  logic                             perf_clear_i,
  output logic [NumPorts-1:0][31:0]        perf_grants_o,
`endif
  input  burst_req_t [NumPorts-1:0]        burst_req_i,
  input  logic       [NumPorts-1:0]        valid_i,
  output logic       [NumPorts-1:0]        ready_o,
  output meta_t      [NumPorts-1:0]        meta_o,
  output burst_req_t                       burst_req_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  input  meta_t                            meta_i,
  output logic       [NumPorts-1:0]        busy_o
);

  localparam int unsigned IdxW = $clog2(NumPorts);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_q, lock_idx_q;
  logic            lock_q;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] occ_q;
  logic [CntW-1:0] out_q [NumPorts];

  logic [IdxW-1:0] grant, head;
  logic            found, fifo_full, push, pop;

  // Full is judged on registered occupancy so a same-cycle completion never
  // opens a combinational path from meta_i into ready/valid.
  assign fifo_full = (occ_q == CntW'(MaxOutstanding));
  assign head      = fifo_q[rd_ptr_q];
  assign push      = valid_o && ready_i;
  assign pop       = meta_i.trans_complete && (occ_q != '0);

  always_comb begin
    grant = rr_q;
    found = 1'b0;
    if (lock_q) begin
      grant = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NumPorts; k++) begin
        if (!found && valid_i[(32'(rr_q) + k) % NumPorts]) begin
          grant = IdxW'((32'(rr_q) + k) % NumPorts);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_o     = valid_i[grant] && !fifo_full;
    burst_req_o = valid_o ? burst_req_i[grant] : '0;
    ready_o     = '0;
    ready_o[grant] = valid_o && ready_i;
  end

  always_comb begin
    meta_o = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      meta_o[i].backend_idle   = meta_i.backend_idle;
      meta_o[i].trans_complete = pop && (head == IdxW'(i));
      busy_o[i]                = (out_q[i] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      for (int unsigned e = 0; e < MaxOutstanding; e++) fifo_q[e] <= '0;
      for (int unsigned i = 0; i < NumPorts; i++) out_q[i] <= '0;
    end else begin
      // Lock survives a full FIFO because valid_o is low there: neither branch fires.
      if (push) begin
        lock_q <= 1'b0;
        rr_q   <= (grant == IdxW'(NumPorts - 1)) ? '0 : grant + 1'b1;
        fifo_q[wr_ptr_q] <= grant;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end else if (valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q <= occ_q + CntW'(push) - CntW'(pop);
      for (int unsigned i = 0; i < NumPorts; i++) begin
        out_q[i] <= out_q[i] + CntW'(push && (grant == IdxW'(i)))
                             - CntW'(pop && (head == IdxW'(i)));
      end
    end
  end

`ifdef IDMA_FRONTEND_ARBITER_PERF_EN
  logic [NumPorts-1:0][31:0] perf_q;
  assign perf_grants_o = perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (perf_clear_i)                         perf_q[i] <= '0;
        else if (push && (grant == IdxW'(i)))     perf_q[i] <= perf_q[i] + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // A completion with nothing outstanding is dropped; flag it as a protocol slip.
  always @(posedge clk_i) begin
    if (rst_ni && meta_i.trans_complete)
      assert (occ_q != '0) else $warning("trans_complete seen with no outstanding request");
  end
`endif

endmodule

// File: tb/tb_idma_frontend_arbiter.sv
module tb_idma_frontend_arbiter;
  typedef idma_frontend_arbiter_pkg::meta_default_t meta_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0][31:0]  burst_req_i;
  logic [3:0]        valid_i = '0;
  logic [3:0]        ready_o;
  meta_t [3:0]       meta_o;
  logic [31:0]       burst_req_o;
  logic              valid_o;
  logic              ready_i = 1'b0;
  meta_t             meta_i = '0;
  logic [3:0]        busy_o;
`ifdef IDMA_FRONTEND_ARBITER_PERF_EN
  logic              perf_clear_i = 1'b0;
  logic [3:0][31:0]  perf_grants_o;
`endif

  int checks = 0;
  int failures = 0;

  idma_frontend_arbiter #(
    .NumPorts(4), .MaxOutstanding(8), .burst_req_t(logic [31:0]), .meta_t(meta_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef IDMA_FRONTEND_ARBITER_PERF_EN
    .perf_clear_i(perf_clear_i), .perf_grants_o(perf_grants_o),
`endif
    .burst_req_i(burst_req_i), .valid_i(valid_i), .ready_o(ready_o), .meta_o(meta_o),
    .burst_req_o(burst_req_o), .valid_o(valid_o), .ready_i(ready_i), .meta_i(meta_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] tcv();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = meta_o[i].trans_complete;
    return v;
  endfunction

  function automatic logic [3:0] idv();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = meta_o[i].backend_idle;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A request offered but not accepted must be offered again, unchanged, next cycle.
  logic        hold_q = 1'b0;
  logic [31:0] hold_req_q = '0;
  always @(posedge clk) begin
    if (rst_n && hold_q) begin
      assert (valid_o === 1'b1 && burst_req_o === hold_req_q) else begin
        failures++;
        $error("FAIL hold observed=%0h expected=%0h", burst_req_o, hold_req_q);
      end
    end
    hold_q     <= rst_n && valid_o && !ready_i;
    hold_req_q <= burst_req_o;
  end

  logic [3:0] rr_order [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    for (int i = 0; i < 4; i++) burst_req_i[i] = 32'hA000_0000 + 32'(i);
    ready_i = 1'b1;
    step(); step();
    // reset state
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_req", burst_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tc", tcv(), 0);
    rst_n = 1'b1;
    step();

    // single request from port 2, forwarded in the same cycle
    valid_i = 4'b0100;
    meta_i.backend_idle = 1'b1;
    #1;
    chk("p2_req", burst_req_o, 32'hA000_0002);
    chk("p2_valid", valid_o, 1);
    chk("p2_ready", ready_o, 4'b0100);
    chk("idle_bcast", idv(), 4'b1111);
    step();
    valid_i = '0;
    #1;
    chk("p2_busy", busy_o, 4'b0100);
    meta_i.trans_complete = 1'b1;
    #1;
    chk("p2_tc", tcv(), 4'b0100);
    step();
    meta_i.trans_complete = 1'b0;
    #1;
    chk("p2_busy_fall", busy_o, 0);
    chk("p2_tc_low", tcv(), 0);

    // ports 0,1,3 contend; rr pointer sits at 3 after the port-2 grant
    valid_i = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", ready_o, rr_order[k]);
      step();
    end
    valid_i = '0;
    #1;
    chk("rr_busy", busy_o, 4'b1011);
    // completions come back in forwarding order
    meta_i.trans_complete = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_tc", tcv(), rr_order[k]);
      step();
    end
    meta_i.trans_complete = 1'b0;
    #1;
    chk("rr_drained", busy_o, 0);

    // lock: port 1 stalls, port 0 arrives late and must wait
    ready_i = 1'b0;
    valid_i = 4'b0010;
    #1;
    chk("lock_req", burst_req_o, 32'hA000_0001);
    chk("lock_ready0", ready_o, 0);
    step();
    valid_i = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lock_hold", burst_req_o, 32'hA000_0001);
      step();
    end
    ready_i = 1'b1;
    #1;
    chk("lock_accept", ready_o, 4'b0010);
    step();
    valid_i = 4'b0001;
    #1;
    chk("after_lock", ready_o, 4'b0001);
    chk("after_lock_req", burst_req_o, 32'hA000_0000);
    step();

    // fill FIFO: two entries already (1,0), six more from port 3
    valid_i = 4'b1000;
    for (int k = 0; k < 6; k++) step();
    #1;
    chk("full_valid", valid_o, 0);
    chk("full_ready", ready_o, 0);
    chk("full_req", burst_req_o, 0);
    chk("full_busy", busy_o, 4'b1011);
    meta_i.trans_complete = 1'b1;
    #1;
    chk("full_pop_tc", tcv(), 4'b0010);
    chk("full_pop_blocked", valid_o, 0);
    step();
    meta_i.trans_complete = 1'b0;
    #1;
    chk("freed_valid", valid_o, 1);
    chk("freed_ready", ready_o, 4'b1000);
    chk("freed_busy", busy_o, 4'b1001);
    step();
    valid_i = '0;
    meta_i.trans_complete = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("drain_tc", tcv(), (k == 0) ? 4'b0001 : 4'b1000);
      step();
    end
    #1;
    chk("drain_busy", busy_o, 0);
    // completion with nothing outstanding is dropped
    chk("empty_tc", tcv(), 0);
    step();
    meta_i.trans_complete = 1'b0;

    // reset mid-operation clears state; a late completion is dropped
    valid_i = 4'b0100;
    step();
    valid_i = '0;
    #1;
    chk("mid_busy", busy_o, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    step();
    rst_n = 1'b1;
    meta_i.trans_complete = 1'b1;
    #1;
    chk("mid_late_tc", tcv(), 0);
    step();
    meta_i.trans_complete = 1'b0;

`ifdef IDMA_FRONTEND_ARBITER_PERF_EN
    valid_i = 4'b0100;
    for (int k = 0; k < 5; k++) step();
    #1;
    chk("perf_cnt", perf_grants_o[2], 5);
    perf_clear_i = 1'b1;
    step();
    perf_clear_i = 1'b0;
    valid_i = '0;
    #1;
    chk("perf_clear", perf_grants_o[2], 0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
